// File: rtl/comparn_serial.sv
// Multi-cycle magnitude comparator: walks two captured N-bit operands D bits per cycle,
// MSB chunk first, stopping at the first differing chunk.
module comparn_serial #(
   parameter int unsigned N         = 16,
   parameter int unsigned D         = 4,
   parameter bit          SIGNED_EN = 1'b1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [N-1:0] A,
   input  logic [N-1:0] B,
   input  logic         is_signed,
   output logic         busy,
   output logic         done,
   output logic         AeqB,
   output logic         AgtB,
   output logic         AltB
);

   localparam int unsigned C  = N / D;
   localparam int unsigned IW = (C > 1) ? $clog2(C) : 1;
   localparam logic [N-1:0] MsbMask = {1'b1, {(N-1){1'b0}}};

   typedef enum logic {StIdle, StRun} state_e;

   state_e        state_q, state_d;
   logic [N-1:0]  a_q, a_d, b_q, b_d;
   logic [IW-1:0] idx_q, idx_d;
   logic          done_q, done_d;
   logic          eq_q, eq_d, gt_q, gt_d, lt_q, lt_d;
   logic [D-1:0]  a_chunk, b_chunk;
   logic          sgn;

   assign sgn = is_signed & SIGNED_EN;

   always_comb begin
      a_chunk = '0;
      b_chunk = '0;
      for (int unsigned i = 0; i < C; i++) begin
         if (idx_q == IW'(i)) begin
            a_chunk = a_q[i*D +: D];
            b_chunk = b_q[i*D +: D];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      idx_d   = idx_q;
      done_d  = 1'b0;
      eq_d    = eq_q;
      gt_d    = gt_q;
      lt_d    = lt_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StRun;
               // Signed compare becomes unsigned once the sign bits are flipped (offset binary).
               a_d     = A ^ (sgn ? MsbMask : '0);
               b_d     = B ^ (sgn ? MsbMask : '0);
               idx_d   = IW'(C - 1);
            end
         end
         StRun: begin
            if ((a_chunk != b_chunk) || (idx_q == '0)) begin
               state_d = StIdle;
               done_d  = 1'b1;
               eq_d    = (a_chunk == b_chunk);
               gt_d    = (a_chunk > b_chunk);
               lt_d    = (a_chunk < b_chunk);
            end else begin
               idx_d = idx_q - IW'(1);
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         a_q     <= '0;
         b_q     <= '0;
         idx_q   <= '0;
         done_q  <= 1'b0;
         eq_q    <= 1'b0;
         gt_q    <= 1'b0;
         lt_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         idx_q   <= idx_d;
         done_q  <= done_d;
         eq_q    <= eq_d;
         gt_q    <= gt_d;
         lt_q    <= lt_d;
      end
   end

   assign busy = (state_q == StRun);
   assign done = done_q;
   assign AeqB = eq_q;
   assign AgtB = gt_q;
   assign AltB = lt_q;

endmodule

// File: tb/tb_comparn_serial.sv
// Bench for comparn_serial: table of operations scored through an expected-result queue,
// plus hand sequences for busy-start, back-to-back, mid-run reset and the D==N variant.
module tb_comparn_serial;

   logic        clk = 1'b0;
   logic        rst, start, is_signed;
   logic [15:0] A, B;
   logic        busy, done, AeqB, AgtB, AltB;

   logic        start2, is_signed2;
   logic [7:0]  A2, B2;
   logic        busy2, done2, AeqB2, AgtB2, AltB2;

   always #5 clk = ~clk;

   comparn_serial #(.N(16), .D(4), .SIGNED_EN(1'b1)) dut (
      .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .is_signed(is_signed),
      .busy(busy), .done(done), .AeqB(AeqB), .AgtB(AgtB), .AltB(AltB)
   );

   comparn_serial #(.N(8), .D(8), .SIGNED_EN(1'b0)) dut2 (
      .clk(clk), .rst(rst), .start(start2), .A(A2), .B(B2), .is_signed(is_signed2),
      .busy(busy2), .done(done2), .AeqB(AeqB2), .AgtB(AgtB2), .AltB(AltB2)
   );

   typedef struct {
      logic [2:0] flags;  // {eq, gt, lt}
      int         cyc;
   } exp_t;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        s;
      int          lat;
      logic [2:0]  flags;
   } vec_t;

   exp_t q[$];
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual %0d required %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   // Monitor: every completion must match the oldest expectation.
   always @(posedge clk) begin
      exp_t e;
      cyc = cyc + 1;
      #1;
      if (done) begin
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done actual 1 required 0 (t=%0t)", $time);
         end else begin
            e = q.pop_front();
            chk("result_flags", int'({AeqB, AgtB, AltB}), int'(e.flags));
            chk("done_cycle", cyc, e.cyc);
            chk("busy_at_done", int'(busy), 0);
         end
      end
   end

   task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic s,
                        input int lat, input logic [2:0] flags);
      exp_t e;
      @(negedge clk);
      A = a; B = b; is_signed = s; start = 1'b1;
      e.flags = flags;
      e.cyc   = cyc + 1 + lat;
      q.push_back(e);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_empty(input int budget);
      int n = 0;
      while (q.size() != 0 && n < budget) begin
         @(posedge clk);
         #2;
         n++;
      end
      if (q.size() != 0) begin
         chk("completion_timeout", q.size(), 0);
         q.delete();
      end
   endtask

   vec_t vecs[11];

   initial begin
      exp_t e;
      vecs[0]  = '{16'h1234, 16'h1234, 1'b0, 4, 3'b100};
      vecs[1]  = '{16'h8000, 16'h7FFF, 1'b0, 1, 3'b010};
      vecs[2]  = '{16'h8000, 16'h7FFF, 1'b1, 1, 3'b001};
      vecs[3]  = '{16'h1235, 16'h1234, 1'b0, 4, 3'b010};
      vecs[4]  = '{16'h0F00, 16'h0E00, 1'b0, 2, 3'b010};
      vecs[5]  = '{16'h0000, 16'h0001, 1'b0, 4, 3'b001};
      vecs[6]  = '{16'hFFFF, 16'h0001, 1'b1, 1, 3'b001};
      vecs[7]  = '{16'hFFFE, 16'hFFFF, 1'b1, 4, 3'b001};
      vecs[8]  = '{16'h00F0, 16'h0100, 1'b0, 2, 3'b001};
      vecs[9]  = '{16'h1230, 16'h1240, 1'b0, 3, 3'b001};
      vecs[10] = '{16'h8000, 16'h8000, 1'b1, 4, 3'b100};

      rst = 1'b1; start = 1'b0; A = '0; B = '0; is_signed = 1'b0;
      start2 = 1'b0; A2 = '0; B2 = '0; is_signed2 = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_outputs", int'({busy, done, AeqB, AgtB, AltB}), 0);
      rst = 1'b0;

      foreach (vecs[i]) begin
         do_op(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].lat, vecs[i].flags);
         wait_empty(20);
      end

      // start held high while busy, operands scrambled: only one op, captured copies used.
      @(negedge clk);
      A = 16'h1234; B = 16'h1234; is_signed = 1'b0; start = 1'b1;
      e.flags = 3'b100;
      e.cyc   = cyc + 5;
      q.push_back(e);
      repeat (4) begin
         @(negedge clk);
         A = 16'h0000; B = 16'hFFFF;
      end
      @(negedge clk);
      start = 1'b0;
      repeat (6) @(negedge clk);
      chk("busy_after_ignored_starts", int'(busy), 0);
      chk("queue_after_ignored_starts", q.size(), 0);

      // Back-to-back: second start lands in the done cycle; old flags held until it completes.
      do_op(16'h0F00, 16'h0E00, 1'b0, 2, 3'b010);
      wait_empty(20);
      do_op(16'h0001, 16'h0002, 1'b0, 4, 3'b001);
      chk("busy_second_op", int'(busy), 1);
      chk("flags_held_during_op", int'({AeqB, AgtB, AltB}), 3'b010);
      wait_empty(20);

      // Reset in the second RUN cycle aborts with no done pulse.
      @(negedge clk);
      A = 16'hFFFF; B = 16'hFFFF; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      chk("busy_before_abort", int'(busy), 1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("outputs_after_abort", int'({busy, done, AeqB, AgtB, AltB}), 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      chk("no_done_after_abort", q.size(), 0);
      do_op(16'h1234, 16'h1234, 1'b0, 4, 3'b100);
      wait_empty(20);

      // D == N, SIGNED_EN=0: single-cycle, is_signed ignored.
      @(negedge clk);
      A2 = 8'hFF; B2 = 8'h01; is_signed2 = 1'b1; start2 = 1'b1;
      @(posedge clk);
      #1;
      chk("dn_busy", int'(busy2), 1);
      @(negedge clk);
      start2 = 1'b0;
      @(posedge clk);
      #1;
      chk("dn_done", int'(done2), 1);
      chk("dn_flags", int'({AeqB2, AgtB2, AltB2}), 3'b010);
      chk("dn_busy_clear", int'(busy2), 0);

      repeat (3) @(negedge clk);
      chk("queue_drained", q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
